rr_stream_mux: RTL

- Parametrised N-to-1 data multiplexer, successor to the fixed 64-bit 2:1 mux.
- Channel select is no longer an external pin. A round-robin arbiter picks among N valid/ready input streams.
- Data passes through one registered output stage with valid/ready backpressure.
- Sits between multiple producers (e.g. datapath lanes) and a single shared consumer.

---
 rtl/rr_stream_mux_pkg.sv | 12 +
 rtl/rr_stream_mux_if.sv | 32 +++
 rtl/rr_stream_mux_arbiter.sv | 35 +++
 rtl/rr_stream_mux.sv | 75 +++++++
 4 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Provides the default data width and the channel-index width function.
package mux_pkg;

    localparam int DEF_WIDTH = 64;

    // Index width for n channels, never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
// Ports: in_valid/in_ready/in_data (N lanes), out_valid/out_ready/out_data/out_sel.
interface rr_stream_mux_if
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = 2
) ();

    localparam int SEL_W = sel_w(N);

    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;

    // Producers and consumer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    // Multiplexer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins.
// Ports: req, ptr, en in; one-hot gnt (gated by en), gnt_idx, any out.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [sel_w(N)-1:0]  ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [sel_w(N)-1:0]  gnt_idx,
    output logic                 any
);

    localparam int SEL_W = sel_w(N);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt_idx = SEL_W'(j);
                gnt[j]  = en;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-to-1 round-robin stream mux with one registered, backpressured output stage.
// Ports: clk, rst (sync, active-high), bus (slave modport); optional
// xfer_count[31:0] when RR_STREAM_MUX_STATS_EN is defined.
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = 2
) (
    input  logic                clk,
    input  logic                rst,
    rr_stream_mux_if.slave      bus
`ifdef RR_STREAM_MUX_STATS_EN
    ,
    output logic [31:0]         xfer_count
`endif
);

    localparam int SEL_W = sel_w(N);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [SEL_W-1:0] gnt_idx;
    logic [N-1:0]     gnt;
    logic             any;
    logic             load;
    logic             en;

    // Register is free when empty or being drained this cycle.
    assign load = !bus.out_valid || bus.out_ready;
    assign en   = load && !rst;

    rr_arbiter #(.N(N)) u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .en      (en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign bus.in_ready = gnt;

    // Pointer moves just past the winner, wrapping at N-1.
    assign ptr_nxt = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            ptr           <= '0;
        end else if (load) begin
            if (any) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.in_data[gnt_idx*WIDTH +: WIDTH];
                bus.out_sel   <= gnt_idx;
                ptr           <= ptr_nxt;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef RR_STREAM_MUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            xfer_count <= xfer_count + 32'd1;
        end
    end
`endif

endmodule
